// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file and its scoreboard.
package rf_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   // Widest busy vector popcount accepts (AW up to 10).
   localparam int PC_W = 1024;

   typedef logic [AW_DEF-1:0] reg_addr_t;

   function automatic int unsigned popcount(input logic [PC_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int k = 0; k < PC_W; k++) begin
         n = n + 32'(v[k]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue and
// cleared at writeback. A same-cycle issue wins over a retiring write
// because the new producer is still outstanding.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int NW       = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NW-1:0]       wen,
   input  logic [NW*AW-1:0]    waddr,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_dst,
   output logic [(2**AW)-1:0]  busy,
   output logic [AW:0]         busy_cnt
);

   localparam int N = 2**AW;

   logic [N-1:0] busy_nxt;

   // Clears from writeback first, then the issue set so it takes priority.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NW; j++) begin
         if (wen[j]) begin
            busy_nxt[waddr[j*AW +: AW]] = 1'b0;
         end
      end
      if (iss_en) begin
         busy_nxt[iss_dst] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_nxt[0] = 1'b0;
      end
   end

   // Busy vector and its count move together on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= (AW+1)'(popcount(PC_W'(busy_nxt)));
      end
   end

endmodule

// File: rtl/rf_multiport_sb.sv
// NR-read / NW-write register file with same-cycle write bypass, optional
// hardwired zero register and a pending-write scoreboard for decode stalls.
module rf_multiport_sb
   import rf_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int NR       = 2,
   parameter int NW       = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NR*AW-1:0]    raddr,
   output logic [NR*DW-1:0]    rdata,
   output logic [NR-1:0]       rbusy,
   input  logic [NW*AW-1:0]    waddr,
   input  logic [NW*DW-1:0]    wdata,
   input  logic [NW-1:0]       wen,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_dst,
   output logic                stall,
   input  logic [NR-1:0]       rreq,
   output logic [AW:0]         busy_cnt
);

   localparam int N = 2**AW;

   logic [DW-1:0] regs [N];
   logic [N-1:0]  busy;

   rf_scoreboard #(
      .AW       (AW),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .wen      (wen),
      .waddr    (waddr),
      .iss_en   (iss_en),
      .iss_dst  (iss_dst),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   // Storage; ascending port loop lets the highest-indexed port win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (wen[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0))) begin
               regs[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
            end
         end
      end
   end

   // Read muxes with bypass; a bypassed operand is never reported busy
   // since the producer's value is on the write bus this cycle.
   always_comb begin
      logic [AW-1:0] ra;
      logic          hit;
      logic          zero_hit;
      logic [DW-1:0] val;
      rdata    = '0;
      rbusy    = '0;
      ra       = '0;
      hit      = 1'b0;
      zero_hit = 1'b0;
      val      = '0;
      for (int i = 0; i < NR; i++) begin
         ra       = raddr[i*AW +: AW];
         hit      = 1'b0;
         val      = regs[ra];
         zero_hit = (ZERO_REG != 0) && (ra == '0);
         for (int j = 0; j < NW; j++) begin
            if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
               hit = 1'b1;
               val = wdata[j*DW +: DW];
            end
         end
         if (zero_hit || rst) begin
            val = '0;
         end
         rdata[i*DW +: DW] = val;
         rbusy[i]          = busy[ra] && !hit && !zero_hit && !rst;
      end
   end

   assign stall = |(rbusy & rreq);

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Scoreboard bench for rf_multiport_sb (NR=2, NW=2, ZERO_REG=1).
module tb_rf_multiport_sb;
   import rf_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int N  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [NW*AW-1:0]  waddr;
   logic [NW*DW-1:0]  wdata;
   logic [NW-1:0]     wen;
   logic              iss_en;
   logic [AW-1:0]     iss_dst;
   logic              stall;
   logic [NR-1:0]     rreq;
   logic [AW:0]       busy_cnt;

   rf_multiport_sb #(
      .DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .waddr    (waddr),
      .wdata    (wdata),
      .wen      (wen),
      .iss_en   (iss_en),
      .iss_dst  (iss_dst),
      .stall    (stall),
      .rreq     (rreq),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [NR*DW-1:0] rdata;
      logic [NR-1:0]    rbusy;
      logic             stall;
      logic [AW:0]      cnt;
   } exp_t;

   exp_t          exq[$];
   logic [DW-1:0] mregs [N];
   bit            mbusy [N];
   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;

   task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
      end
   endtask

   // Monitor: outputs are combinational, so one expectation per cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      if (exq.size() > 0) begin
         e = exq.pop_front();
         chk("rdata0",   e.cyc, 64'(rdata[31:0]),  64'(e.rdata[31:0]));
         chk("rdata1",   e.cyc, 64'(rdata[63:32]), 64'(e.rdata[63:32]));
         chk("rbusy",    e.cyc, 64'(rbusy),        64'(e.rbusy));
         chk("stall",    e.cyc, 64'(stall),        64'(e.stall));
         chk("busy_cnt", e.cyc, 64'(busy_cnt),     64'(e.cnt));
      end
   end

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mregs[k] = '0;
         mbusy[k] = 1'b0;
      end
   endtask

   // Drive one cycle, predict its outputs, then advance the model at the edge.
   task automatic step(input logic r, input reg_addr_t ra0, input reg_addr_t ra1,
                       input logic [1:0] rq, input logic [1:0] we,
                       input reg_addr_t wa0, input reg_addr_t wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic ie, input reg_addr_t id);
      exp_t          e;
      reg_addr_t     ra [2];
      reg_addr_t     wa [2];
      logic [31:0]   wd [2];
      logic [31:0]   v;
      bit            wr;
      int            n;
      #1;
      rst     = r;
      raddr   = {ra1, ra0};
      rreq    = rq;
      wen     = we;
      waddr   = {wa1, wa0};
      wdata   = {wd1, wd0};
      iss_en  = ie;
      iss_dst = id;
      ra[0] = ra0; ra[1] = ra1;
      wa[0] = wa0; wa[1] = wa1;
      wd[0] = wd0; wd[1] = wd1;
      e.cyc   = cyc;
      e.rdata = '0;
      e.rbusy = '0;
      e.stall = 1'b0;
      e.cnt   = '0;
      if (!r) begin
         for (int i = 0; i < 2; i++) begin
            v  = mregs[ra[i]];
            wr = 1'b0;
            for (int j = 0; j < 2; j++) begin
               if (we[j] && wa[j] == ra[i]) begin
                  v  = wd[j];
                  wr = 1'b1;
               end
            end
            if (ra[i] == 0) v = '0;
            e.rdata[i*32 +: 32] = v;
            e.rbusy[i] = (ra[i] != 0) && mbusy[ra[i]] && !wr;
         end
         e.stall = |(e.rbusy & rq);
         n = 0;
         for (int k = 0; k < N; k++) n += int'(mbusy[k]);
         e.cnt = (AW+1)'(n);
      end
      exq.push_back(e);
      @(posedge clk);
      cyc++;
      if (r) begin
         model_reset();
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (we[j]) begin
               if (wa[j] != 0) mregs[wa[j]] = wd[j];
               mbusy[wa[j]] = 1'b0;
            end
         end
         if (ie && id != 0) mbusy[id] = 1'b1;
      end
   endtask

   function automatic reg_addr_t pick();
      if ($urandom_range(0, 3) == 0) return reg_addr_t'($urandom_range(0, 31));
      return reg_addr_t'($urandom_range(0, 7));
   endfunction

   task automatic rnd_step();
      step(1'b0, pick(), pick(), 2'($urandom), 2'($urandom), pick(), pick(),
           $urandom, $urandom, 1'($urandom_range(0, 1)), pick());
   endtask

   initial begin
      rst = 1'b1; raddr = '0; rreq = '0; wen = '0; waddr = '0; wdata = '0;
      iss_en = 1'b0; iss_dst = '0;
      model_reset();
      @(posedge clk);
      step(1, 5, 7, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      step(1, 5, 7, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      // write then read, zero register
      step(0, 0, 0, 2'b00, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0);
      step(0, 5, 0, 2'b01, 2'b01, 0, 0, 32'h1234, 0, 0, 0);
      step(0, 0, 5, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      // same-cycle bypass of a busy register
      step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 7);
      step(0, 0, 7, 2'b10, 2'b01, 7, 0, 32'hA5A5A5A5, 0, 0, 0);
      // hazard on r3 and its resolution
      step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 3);
      step(0, 3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      step(0, 3, 0, 2'b01, 2'b01, 3, 0, 9, 0, 0, 0);
      step(0, 3, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      // set/clear collision on r4
      step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4);
      step(0, 4, 0, 2'b01, 2'b01, 4, 0, 32'h44, 0, 1, 4);
      step(0, 4, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
      // issue to r0 is ignored
      step(0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 0);
      step(0, 0, 4, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      // write-port conflict on r9
      step(0, 9, 9, 2'b00, 2'b11, 9, 9, 32'h11, 32'h22, 0, 0);
      step(0, 9, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      for (int t = 0; t < 400; t++) rnd_step();
      // mid-run reset with outstanding producers
      step(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 2);
      step(0, 2, 6, 2'b11, 2'b00, 0, 0, 0, 0, 1, 6);
      step(1, 2, 6, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      step(1, 9, 5, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      step(0, 2, 9, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
      for (int t = 0; t < 200; t++) rnd_step();
      @(negedge clk);
      #1;
      chk("queue_drained", cyc, 64'(exq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
